pulse_generator: RTL

Converts single-cycle event pulses into timed level pulses, the inverse of the edge detectors. Each accepted trigger produces a `signal` high window of HIGH_CYCLES, followed by a mandatory low gap of GAP_CYCLES. Triggers that arrive while a pulse is in progress are queued in a saturating pending counter. The block drives LEDs, strobes and handshake lines from event pulses produced elsewhere in the design. Feeding `signal` into a rising edge detector recovers one event per accepted trigger.

---
 rtl/pulse_pkg.sv | 24 ++
 rtl/pulse_generator_sat_updown_counter.sv | 58 +++++
 rtl/pulse_generator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and width helpers for the pulse generator.
package pulse_pkg;

   // Pulse FSM encoding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2
   } pulse_state_t;

   // Down counter must hold the larger of the two phase lengths.
   function automatic int unsigned cnt_width(input int unsigned high_cycles,
                                             input int unsigned gap_cycles);
      int unsigned max_len;
      max_len = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
      return $clog2(max_len + 1);
   endfunction

   // Width needed to count 0..depth.
   function automatic int unsigned pend_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pulse_generator_sat_updown_counter.sv
// Saturating up/down counter with clear, full flag and registered overflow pulse.
module sat_updown_counter
   import pulse_pkg::*;
#(
   parameter int unsigned MAX = 3
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_inc,
   input  logic                      i_dec,
   input  logic                      i_clr,
   output logic [$clog2(MAX+1)-1:0]  o_count,
   output logic                      o_full,
   output logic                      o_overflow
);

   localparam int unsigned W = $clog2(MAX + 1);

   logic [W-1:0] r_count;
   logic         r_overflow;
   logic [W-1:0] w_count_next;
   logic         w_overflow_next;

   // Next count: clear wins, inc+dec cancel, saturate at both ends.
   always_comb begin
      w_count_next    = r_count;
      w_overflow_next = 1'b0;
      if (i_clr) begin
         w_count_next = '0;
      end else if (i_inc && !i_dec) begin
         if (r_count == W'(MAX)) begin
            w_overflow_next = 1'b1;
         end else begin
            w_count_next = r_count + W'(1);
         end
      end else if (i_dec && !i_inc) begin
         if (r_count != '0) begin
            w_count_next = r_count - W'(1);
         end
      end
   end

   // Count and overflow state with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_count    <= w_count_next;
         r_overflow <= w_overflow_next;
      end
   end

   assign o_count    = r_count;
   assign o_full     = (r_count == W'(MAX));
   assign o_overflow = r_overflow;

endmodule

// File: rtl/pulse_generator.sv
// Turns single-cycle trigger events into HIGH_CYCLES-wide level pulses separated by
// at least GAP_CYCLES low cycles, queueing triggers that arrive mid-pulse.
module pulse_generator
   import pulse_pkg::*;
#(
   parameter int unsigned HIGH_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned PEND_DEPTH  = 3,
   parameter bit          RETRIGGER   = 1'b0
) (
   input  logic                             i_clk,
   input  logic                             i_reset,
   input  logic                             i_trigger,
   input  logic                             i_cancel,
   output logic                             o_signal,
   output logic                             o_busy,
   output logic                             o_done,
   output logic                             o_dropped,
   output logic [$clog2(PEND_DEPTH+1)-1:0]  o_pending
);

   if (HIGH_CYCLES < 1) begin : g_high_chk
      $error("pulse_generator: HIGH_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_gap_chk
      $error("pulse_generator: GAP_CYCLES must be >= 1");
   end
   if (PEND_DEPTH < 1) begin : g_pend_chk
      $error("pulse_generator: PEND_DEPTH must be >= 1");
   end

   localparam int unsigned CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
   localparam int unsigned PW = pend_width(PEND_DEPTH);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_HIGH = HIGH;
   localparam logic [1:0] ST_GAP  = GAP;

   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_signal;
   logic          r_busy;
   logic          r_done;

   logic [1:0]    w_state_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_done_next;
   logic          w_expire;
   logic          w_pend_inc;
   logic          w_pend_dec;
   logic          w_pend_clr;
   logic [PW-1:0] w_pend_count;
   logic          w_pend_ovf;
   // Overflow already reports drops, so the full flag is not needed here.
   logic          w_unused_full;

   // Counter value 1 marks the last cycle of the current phase.
   assign w_expire = (r_cnt <= CW'(1));

   // FSM next state, counter reload and queue updates.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = (r_cnt != '0) ? (r_cnt - CW'(1)) : r_cnt;
      w_done_next  = 1'b0;
      w_pend_inc   = 1'b0;
      w_pend_dec   = 1'b0;
      w_pend_clr   = 1'b0;
      if (i_cancel) begin
         // Abort: trigger in the same cycle is ignored, no done pulse.
         w_state_next = ST_IDLE;
         w_cnt_next   = '0;
         w_pend_clr   = 1'b1;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_trigger) begin
                  w_state_next = ST_HIGH;
                  w_cnt_next   = HIGH_LOAD;
               end
            end
            ST_HIGH: begin
               if (i_trigger && RETRIGGER) begin
                  w_cnt_next = HIGH_LOAD;
               end else begin
                  w_pend_inc = i_trigger;
                  if (w_expire) begin
                     w_state_next = ST_GAP;
                     w_cnt_next   = GAP_LOAD;
                     w_done_next  = 1'b1;
                  end
               end
            end
            ST_GAP: begin
               w_pend_inc = i_trigger;
               if (w_expire) begin
                  if (w_pend_count != '0) begin
                     // Dequeue; a same-cycle trigger re-queues so the count holds.
                     w_state_next = ST_HIGH;
                     w_cnt_next   = HIGH_LOAD;
                     w_pend_dec   = 1'b1;
                  end else if (i_trigger) begin
                     // Empty queue: the trigger starts the next pulse directly.
                     w_state_next = ST_HIGH;
                     w_cnt_next   = HIGH_LOAD;
                     w_pend_inc   = 1'b0;
                  end else begin
                     w_state_next = ST_IDLE;
                     w_cnt_next   = '0;
                  end
               end
            end
            default: begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   // State, counter and registered outputs derived from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_signal <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_signal <= (w_state_next == ST_HIGH);
         r_busy   <= (w_state_next != ST_IDLE);
         r_done   <= w_done_next;
      end
   end

   sat_updown_counter #(
      .MAX (PEND_DEPTH)
   ) u_pending (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (w_pend_inc),
      .i_dec      (w_pend_dec),
      .i_clr      (w_pend_clr),
      .o_count    (w_pend_count),
      .o_full     (w_unused_full),
      .o_overflow (w_pend_ovf)
   );

   assign o_signal  = r_signal;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_dropped = w_pend_ovf;
   assign o_pending = w_pend_count;

endmodule
